// File: rtl/rv32i_types.sv
// Shared RV32I type package: branch funct3 encodings plus the branch predictor's
// 2-bit counter type, its reset value and a funct3 legality helper.
package rv32i_types;

   typedef enum logic [2:0] {
      F3_BEQ  = 3'b000,
      F3_BNE  = 3'b001,
      F3_BLT  = 3'b100,
      F3_BGE  = 3'b101,
      F3_BLTU = 3'b110,
      F3_BGEU = 3'b111
   } branch_funct3_t;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bp_ctr_t;

   localparam bp_ctr_t BP_CTR_RESET = WNT;

   // 010 and 011 fall outside the branch opcode space and are never trained on.
   function automatic logic bp_funct3_legal(input branch_funct3_t f3);
      case (f3)
         F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU: return 1'b1;
         default:                                          return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating counter next-state logic: count up on taken, down on not
// taken, holding at ST and SNT respectively.
module sat_counter2
   import rv32i_types::*;
(
   input  bp_ctr_t cur,
   input  logic    taken,
   output bp_ctr_t nxt
);

   always_comb begin
      nxt = cur;
      case (cur)
         SNT:     nxt = taken ? WNT : SNT;
         WNT:     nxt = taken ? WT  : SNT;
         WT:      nxt = taken ? ST  : WNT;
         ST:      nxt = taken ? ST  : WT;
         default: nxt = BP_CTR_RESET;
      endcase
   end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch-direction predictor with mispredict flag and statistics.
// Define BRANCH_PREDICTOR_GSHARE_EN to XOR a global history into both indices.
module branch_predictor
   import rv32i_types::*;
#(
   parameter int INDEX_BITS = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pred_req,
   input  logic [31:0]           pred_pc,
   output logic                  pred_rsp_valid,
   output logic                  pred_taken,
   output logic [INDEX_BITS-1:0] pred_ghr,
   input  logic                  upd_valid,
   input  logic [31:0]           upd_pc,
   input  logic [2:0]            upd_funct3,
   input  logic                  upd_taken,
   input  logic                  upd_pred,
   input  logic [INDEX_BITS-1:0] upd_ghr,
   output logic                  mispredict,
   output logic [31:0]           branch_count,
   output logic [31:0]           mispredict_count
);

   localparam int TABLE_SIZE = 1 << INDEX_BITS;

   // Handshake: pred_req and upd_valid are single-cycle valid strobes with no
   // ready/backpressure; every strobe is consumed at the edge that samples it.

   bp_ctr_t               ctr_table [TABLE_SIZE];
   logic [INDEX_BITS-1:0] pred_pc_idx;
   logic [INDEX_BITS-1:0] upd_pc_idx;
   logic [INDEX_BITS-1:0] lookup_idx;
   logic [INDEX_BITS-1:0] update_idx;
   logic [INDEX_BITS-1:0] ghr_snap;
   logic                  upd_accept;
   bp_ctr_t               lookup_ctr;
   bp_ctr_t               upd_ctr_cur;
   bp_ctr_t               upd_ctr_nxt;

   assign pred_pc_idx = pred_pc[INDEX_BITS+1:2];
   assign upd_pc_idx  = upd_pc[INDEX_BITS+1:2];
   assign upd_accept  = upd_valid && bp_funct3_legal(branch_funct3_t'(upd_funct3));

`ifdef BRANCH_PREDICTOR_GSHARE_EN
   logic [INDEX_BITS-1:0] ghr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ghr <= '0;
      end else if (upd_accept) begin
         ghr <= {ghr[INDEX_BITS-2:0], upd_taken};
      end
   end

   assign lookup_idx = pred_pc_idx ^ ghr;
   assign update_idx = upd_pc_idx ^ upd_ghr;
   assign ghr_snap   = ghr;

   logic unused_pc_bits;
   assign unused_pc_bits = ^{pred_pc[31:INDEX_BITS+2], pred_pc[1:0],
                             upd_pc[31:INDEX_BITS+2], upd_pc[1:0]};
`else
   assign lookup_idx = pred_pc_idx;
   assign update_idx = upd_pc_idx;
   assign ghr_snap   = '0;

   logic unused_pc_bits;
   assign unused_pc_bits = ^{pred_pc[31:INDEX_BITS+2], pred_pc[1:0],
                             upd_pc[31:INDEX_BITS+2], upd_pc[1:0], upd_ghr};
`endif

   assign lookup_ctr  = ctr_table[lookup_idx];
   assign upd_ctr_cur = ctr_table[update_idx];

   sat_counter2 u_sat_counter2 (
      .cur   (upd_ctr_cur),
      .taken (upd_taken),
      .nxt   (upd_ctr_nxt)
   );

   // Table write lands at the edge; a same-cycle lookup already captured the old value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < TABLE_SIZE; i++) begin
            ctr_table[i] <= BP_CTR_RESET;
         end
      end else if (upd_accept) begin
         ctr_table[update_idx] <= upd_ctr_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pred_rsp_valid <= 1'b0;
         pred_taken     <= 1'b0;
         pred_ghr       <= '0;
      end else begin
         pred_rsp_valid <= pred_req;
         if (pred_req) begin
            pred_taken <= lookup_ctr[1];
            pred_ghr   <= ghr_snap;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mispredict       <= 1'b0;
         branch_count     <= '0;
         mispredict_count <= '0;
      end else begin
         mispredict <= upd_accept && (upd_taken != upd_pred);
         if (upd_accept) begin
            branch_count <= branch_count + 32'd1;
            if (upd_taken != upd_pred) begin
               mispredict_count <= mispredict_count + 32'd1;
            end
         end
      end
   end

endmodule
